// File: rtl/ov7670_capture_ctrl.sv
// Capture control for the OV7670 path. The debounced button is classified into
// short and long presses. A short press toggles frame freeze, and the toggle
// is applied only at the next vsync rising edge. A long press requests a camera
// re-configuration and holds off frame-buffer writes until the sequencer is done.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// LIVE      | frames written to the buffer
// FRZ_PEND  | freeze requested; still writing until the next frame boundary
// FROZEN    | buffer holds the last complete frame; no writes
// LIVE_PEND | unfreeze requested; writes resume at the next frame boundary
// RECFG_LO  | re-configuration requested; waiting for cfg_done to drop
// RECFG_HI  | waiting for cfg_done to rise again
module ov7670_capture_ctrl #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_db,
    input  logic                   vsync,
    input  logic                   cfg_done,
    output logic                   wr_en,
    output logic                   frozen,
    output logic                   cfg_resend,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        LIVE,
        FRZ_PEND,
        FROZEN,
        LIVE_PEND,
        RECFG_LO,
        RECFG_HI
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              btn_q;
    logic              vs_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;
    logic              rise_b;
    logic              fall_b;
    logic              vs_rise;
    logic              long_ev;
    logic              short_ev;

    assign rise_b   = btn_db & ~btn_q;
    assign fall_b   = ~btn_db & btn_q;
    assign vs_rise  = vsync & ~vs_q;
    assign long_ev  = btn_db & (hold_cnt == HOLD_FIRE) & ~long_fired;
    assign short_ev = fall_b & ~long_fired;

    // Registered copies of the button and vsync for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            btn_q <= btn_db;
            vs_q  <= vsync;
        end
    end

    // Press length tracking; long_fired suppresses the short event on release
    // and keeps a press held across a re-configuration from firing twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
        end else if (rise_b) begin
            hold_cnt   <= HOLD_W'(1);
            long_fired <= 1'b0;
        end else begin
            if (!btn_db) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (long_ev) begin
                long_fired <= 1'b1;
            end
        end
    end

    // Next-state selection: long press beats short press beats frame boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            LIVE: begin
                if (long_ev)       state_nxt = RECFG_LO;
                else if (short_ev) state_nxt = FRZ_PEND;
            end
            FRZ_PEND: begin
                if (long_ev)       state_nxt = RECFG_LO;
                else if (short_ev) state_nxt = LIVE;
                else if (vs_rise)  state_nxt = FROZEN;
            end
            FROZEN: begin
                if (long_ev)       state_nxt = RECFG_LO;
                else if (short_ev) state_nxt = LIVE_PEND;
            end
            LIVE_PEND: begin
                if (long_ev)       state_nxt = RECFG_LO;
                else if (short_ev) state_nxt = FROZEN;
                else if (vs_rise)  state_nxt = LIVE;
            end
            RECFG_LO: begin
                if (!cfg_done)     state_nxt = RECFG_HI;
            end
            RECFG_HI: begin
                if (cfg_done)      state_nxt = LIVE_PEND;
            end
            default:               state_nxt = LIVE_PEND;
        endcase
    end

    // State register with outputs decoded from the next state so they change
    // on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LIVE_PEND;
            wr_en      <= 1'b0;
            frozen     <= 1'b0;
            cfg_resend <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_en      <= (state_nxt == LIVE) || (state_nxt == FRZ_PEND);
            frozen     <= (state_nxt == FROZEN);
            cfg_resend <= (state_nxt == RECFG_LO) && (state != RECFG_LO);
            busy       <= (state_nxt == RECFG_LO) || (state_nxt == RECFG_HI);
        end
    end

    // Count frames that began while writes were enabled; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (vs_rise && wr_en) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl: directed scenarios followed by random button,
// vsync and cfg_done activity, all scored against a behavioural model.
module tb_ov7670_capture_ctrl;

    localparam int LONG = 16;
    localparam int FW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          btn_db = 1'b0;
    logic          vsync = 1'b0;
    logic          cfg_done = 1'b1;
    logic          wr_en;
    logic          frozen;
    logic          cfg_resend;
    logic          busy;
    logic [FW-1:0] frame_cnt;

    ov7670_capture_ctrl #(
        .LONG_CYCLES (LONG),
        .HOLD_W      (5),
        .FRAME_CNT_W (FW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_db     (btn_db),
        .vsync      (vsync),
        .cfg_done   (cfg_done),
        .wr_en      (wr_en),
        .frozen     (frozen),
        .cfg_resend (cfg_resend),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr_en;
        logic          frozen;
        logic          cfg_resend;
        logic          busy;
        logic [FW-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: "showing" is either the live feed or a held frame; a pending flag
    // records a requested toggle that lands at the next frame boundary.
    localparam int M_LIVE = 0, M_HELD = 1, M_RC_LO = 2, M_RC_HI = 3;
    int   m_mode;
    bit   m_pend;
    int   m_run;
    bit   m_btn_prev;
    bit   m_vs_prev;
    int   m_frames;
    bit   m_resend;

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mode     = M_HELD;
        m_pend     = 1'b1;
        m_run      = 0;
        m_btn_prev = 1'b0;
        m_vs_prev  = 1'b0;
        m_frames   = 0;
        m_resend   = 1'b0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.wr_en      = (m_mode == M_LIVE);
        e.frozen     = (m_mode == M_HELD) && !m_pend;
        e.cfg_resend = m_resend;
        e.busy       = (m_mode == M_RC_LO) || (m_mode == M_RC_HI);
        e.cnt        = FW'(m_frames % (1 << FW));
        return e;
    endfunction

    function automatic void model_step(input bit b, input bit v, input bit c);
        bit is_long;
        bit is_short;
        bit frame_start;
        is_long     = b && (m_run + 1 == LONG);
        is_short    = !b && m_btn_prev && (m_run < LONG);
        frame_start = v && !m_vs_prev;
        if (frame_start && m_mode == M_LIVE) m_frames++;
        m_resend = 1'b0;
        if (m_mode == M_LIVE || m_mode == M_HELD) begin
            if (is_long) begin
                m_mode   = M_RC_LO;
                m_pend   = 1'b0;
                m_resend = 1'b1;
            end else if (is_short) begin
                m_pend = !m_pend;
            end else if (frame_start && m_pend) begin
                m_mode = (m_mode == M_LIVE) ? M_HELD : M_LIVE;
                m_pend = 1'b0;
            end
        end else if (m_mode == M_RC_LO) begin
            if (!c) m_mode = M_RC_HI;
        end else if (c) begin
            m_mode = M_HELD;
            m_pend = 1'b1;
        end
        m_run      = b ? ((m_run < LONG) ? m_run + 1 : LONG) : 0;
        m_btn_prev = b;
        m_vs_prev  = v;
    endfunction

    task automatic cyc(input bit b, input bit v, input bit c);
        @(negedge clk);
        btn_db   = b;
        vsync    = v;
        cfg_done = c;
        model_step(b, v, c);
        expq.push_back(model_out());
    endtask

    task automatic run(input int n, input bit b, input bit v, input bit c);
        for (int i = 0; i < n; i++) cyc(b, v, c);
    endtask

    task automatic frame_pulse();
        run(1, 0, 1, 1);
        run(2, 0, 1, 1);
        run(2, 0, 0, 1);
    endtask

    task automatic short_press();
        run(3, 1, 0, 1);
        run(2, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_db   = 1'b0;
        vsync    = 1'b0;
        cfg_done = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_frozen", int'(frozen), 0);
        chk("rst_cfg_resend", int'(cfg_resend), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("wr_en", int'(wr_en), int'(mon_e.wr_en));
            chk("frozen", int'(frozen), int'(mon_e.frozen));
            chk("cfg_resend", int'(cfg_resend), int'(mon_e.cfg_resend));
            chk("busy", int'(busy), int'(mon_e.busy));
            chk("frame_cnt", int'(frame_cnt), int'(mon_e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit vs_lvl;
        bit cd_lvl;
        bit b_lvl;
        int len;

        model_reset();
        do_reset();

        // Reset -> LIVE at the first frame boundary, not counted.
        run(19, 0, 0, 1);
        frame_pulse();

        // Short press in LIVE, freeze lands on the next vsync rise.
        run(5, 1, 0, 1);
        run(10, 0, 0, 1);
        frame_pulse();

        // Unfreeze, then a cancelled freeze in LIVE.
        short_press();
        frame_pulse();
        short_press();
        short_press();
        frame_pulse();

        // Long press: one resend pulse, no short on release, wait for cfg_done.
        run(40, 1, 0, 1);
        run(3, 0, 0, 1);
        run(4, 0, 0, 0);
        run(3, 0, 0, 1);
        frame_pulse();

        // Simultaneous release and frame start in FRZ_PEND and LIVE_PEND.
        short_press();
        run(3, 1, 0, 1);
        run(1, 0, 1, 1);
        run(2, 0, 1, 1);
        run(2, 0, 0, 1);
        short_press();
        frame_pulse();
        short_press();
        run(3, 1, 0, 1);
        run(1, 0, 1, 1);
        run(2, 0, 1, 1);
        run(2, 0, 0, 1);

        // Back to LIVE, 17 counted frames to force a wrap.
        short_press();
        frame_pulse();
        for (int i = 0; i < 17; i++) frame_pulse();

        // Long press then reset while stuck in RECFG_HI.
        run(LONG + 2, 1, 0, 1);
        run(2, 0, 0, 1);
        run(6, 0, 0, 0);
        do_reset();
        run(4, 0, 0, 0);
        frame_pulse();

        // Random activity with occasional resets.
        vs_lvl = 1'b0;
        cd_lvl = 1'b1;
        b_lvl  = 1'b0;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            b_lvl = !b_lvl;
            len = b_lvl ? (($urandom_range(0, 3) == 0) ? $urandom_range(14, 24)
                                                         : $urandom_range(1, 8))
                        : $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0) vs_lvl = !vs_lvl;
                if ($urandom_range(0, 3) == 0) cd_lvl = !cd_lvl;
                cyc(b_lvl, vs_lvl, cd_lvl);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
